cop_ise_arb: RTL and testbench

COP_ISE_ARB -- requirements
Module: cop_ise_arb

---
 rtl/cop_ise_arb.sv | 182 ++++++++++++++++++
 tb/tb_cop_ise_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_ise_arb.sv
// Two-port arbiter in front of a shared ISE datapath.
// Grants one requester, drives the datapath, returns the result.
//
// Ports:
//   cop_clk, cop_rst        clock, async active-high reset
//   reqN_valid/insn/rs1/rs2 requester N instruction and operands
//   reqN_rdywr              requester N can take a result write
//   reqN_ready/wr/rd        requester N completion, write, data
//   dp_insn/rs1/rs2         operands to the shared datapath
//   dp_sel, dp_rd           datapath decode hit and result
//   arb_busy                high whenever not IDLE
module cop_ise_arb #(
  parameter bit RR = 1'b1
) (
  input  logic        cop_clk,
  input  logic        cop_rst,

  input  logic        req0_valid,
  input  logic [31:0] req0_insn,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic        req0_rdywr,
  output logic        req0_ready,
  output logic        req0_wr,
  output logic [31:0] req0_rd,

  input  logic        req1_valid,
  input  logic [31:0] req1_insn,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic        req1_rdywr,
  output logic        req1_ready,
  output logic        req1_wr,
  output logic [31:0] req1_rd,

  output logic [31:0] dp_insn,
  output logic [31:0] dp_rs1,
  output logic [31:0] dp_rs2,
  input  logic        dp_sel,
  input  logic [31:0] dp_rd,

  output logic        arb_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } op_t;

  state_t      state;
  op_t         op_q;
  logic [31:0] res_q;
  logic        gnt_q;
  logic        last_q;

  logic        any_valid;
  logic        both_valid;
  logic        pick;
  op_t         pick_op;
  logic        gnt_valid;
  logic        gnt_rdywr;

  logic        done;
  logic        wr_g;
  logic [31:0] rd_g;

  assign any_valid  = req0_valid | req1_valid;
  assign both_valid = req0_valid & req1_valid;

  // pick = 1 selects requester 1
  always_comb begin
    pick = 1'b0;
    if (RR) begin
      if (both_valid)
        pick = ~last_q;
      else
        pick = req1_valid;
    end else begin
      pick = ~req0_valid;
    end
  end

  always_comb begin
    pick_op = '0;
    if (pick) begin
      pick_op.insn = req1_insn;
      pick_op.rs1  = req1_rs1;
      pick_op.rs2  = req1_rs2;
    end else begin
      pick_op.insn = req0_insn;
      pick_op.rs1  = req0_rs1;
      pick_op.rs2  = req0_rs2;
    end
  end

  assign gnt_valid = gnt_q ? req1_valid : req0_valid;
  assign gnt_rdywr = gnt_q ? req1_rdywr : req0_rdywr;

  // Every way out of EXEC/RESP lands in IDLE, so a fresh grant
  // is always at least one IDLE cycle away.
  always_ff @(posedge cop_clk or posedge cop_rst) begin
    if (cop_rst) begin
      state  <= IDLE;
      op_q   <= '0;
      res_q  <= '0;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            gnt_q <= pick;
            op_q  <= pick_op;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!gnt_valid) begin
            last_q <= gnt_q;
            state  <= IDLE;
          end else if (dp_sel) begin
            res_q <= dp_rd;
            state <= RESP;
          end else begin
            last_q <= gnt_q;
            state  <= IDLE;
          end
        end
        RESP: begin
          if (!gnt_valid || gnt_rdywr) begin
            last_q <= gnt_q;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state; ready follows the live handshake
  // inputs so it lands in the same cycle as the completing edge.
  always_comb begin
    dp_insn = '0;
    dp_rs1  = '0;
    dp_rs2  = '0;
    done    = 1'b0;
    wr_g    = 1'b0;
    rd_g    = '0;
    unique case (state)
      EXEC: begin
        dp_insn = op_q.insn;
        dp_rs1  = op_q.rs1;
        dp_rs2  = op_q.rs2;
        done    = gnt_valid & ~dp_sel;
      end
      RESP: begin
        wr_g = 1'b1;
        rd_g = res_q;
        done = gnt_valid & gnt_rdywr;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign req0_ready = done & ~gnt_q;
  assign req1_ready = done &  gnt_q;
  assign req0_wr    = wr_g & ~gnt_q;
  assign req1_wr    = wr_g &  gnt_q;
  assign req0_rd    = gnt_q ? '0 : rd_g;
  assign req1_rd    = gnt_q ? rd_g : '0;
  assign arb_busy   = (state != IDLE);

endmodule

// File: tb/tb_cop_ise_arb.sv
// Directed bench for cop_ise_arb, round-robin and fixed variants.
// Datapath model: sel on opcode 0x2B, rd = rs1 ^ rs2.
module tb_cop_ise_arb;

  logic        cop_clk;
  logic        cop_rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_insn, req0_rs1, req0_rs2;
  logic [31:0] req1_insn, req1_rs1, req1_rs2;
  logic        req0_rdywr, req1_rdywr;

  logic        req0_ready, req0_wr, req1_ready, req1_wr;
  logic [31:0] req0_rd, req1_rd;
  logic [31:0] dp_insn, dp_rs1, dp_rs2, dp_rd;
  logic        dp_sel, arb_busy;

  logic        f0_ready, f0_wr, f1_ready, f1_wr;
  logic [31:0] f0_rd, f1_rd;
  logic [31:0] f_insn, f_rs1, f_rs2, f_rd;
  logic        f_sel, f_busy;

  int checks = 0;
  int errors = 0;

  assign dp_sel = (dp_insn[6:0] == 7'h2B);
  assign dp_rd  = dp_rs1 ^ dp_rs2;
  assign f_sel  = (f_insn[6:0] == 7'h2B);
  assign f_rd   = f_rs1 ^ f_rs2;

  cop_ise_arb #(.RR(1'b1)) u_rr (
    .cop_clk(cop_clk), .cop_rst(cop_rst),
    .req0_valid(req0_valid), .req0_insn(req0_insn),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_rdywr(req0_rdywr), .req0_ready(req0_ready),
    .req0_wr(req0_wr), .req0_rd(req0_rd),
    .req1_valid(req1_valid), .req1_insn(req1_insn),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_rdywr(req1_rdywr), .req1_ready(req1_ready),
    .req1_wr(req1_wr), .req1_rd(req1_rd),
    .dp_insn(dp_insn), .dp_rs1(dp_rs1), .dp_rs2(dp_rs2),
    .dp_sel(dp_sel), .dp_rd(dp_rd), .arb_busy(arb_busy)
  );

  cop_ise_arb #(.RR(1'b0)) u_fp (
    .cop_clk(cop_clk), .cop_rst(cop_rst),
    .req0_valid(req0_valid), .req0_insn(req0_insn),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_rdywr(req0_rdywr), .req0_ready(f0_ready),
    .req0_wr(f0_wr), .req0_rd(f0_rd),
    .req1_valid(req1_valid), .req1_insn(req1_insn),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_rdywr(req1_rdywr), .req1_ready(f1_ready),
    .req1_wr(f1_wr), .req1_rd(f1_rd),
    .dp_insn(f_insn), .dp_rs1(f_rs1), .dp_rs2(f_rs2),
    .dp_sel(f_sel), .dp_rd(f_rd), .arb_busy(f_busy)
  );

  initial cop_clk = 1'b0;
  always #5 cop_clk = ~cop_clk;

  task automatic tick();
    @(posedge cop_clk);
    #2;
  endtask

  task automatic test_reset();
    cop_rst = 1'b1;
    tick();
    tick();
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", arb_busy);
    end
    checks++;
    if ({req0_ready, req0_wr, req1_ready, req1_wr} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 0",
               {req0_ready, req0_wr, req1_ready, req1_wr});
    end
    checks++;
    if ({req0_rd, req1_rd, dp_insn, dp_rs1, dp_rs2} !== '0) begin
      errors++;
      $display("FAIL rst_data got %h %h %h want 0",
               req0_rd, req1_rd, dp_insn);
    end
    checks++;
    if (f_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_fp_busy got %b want 0", f_busy);
    end
    cop_rst = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_insn  = 32'h4000002B;
    req0_rs1   = 32'h12345678;
    req0_rs2   = 32'h0;
    req0_rdywr = 1'b1;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_t_busy got %b want 0", arb_busy);
    end
    tick();
    req0_insn = 32'hFFFFFFFF;
    req0_rs1  = 32'h0;
    #1;
    checks++;
    if (dp_insn !== 32'h4000002B || dp_rs1 !== 32'h12345678) begin
      errors++;
      $display("FAIL single_dp got %h %h want 4000002b 12345678",
               dp_insn, dp_rs1);
    end
    checks++;
    if (arb_busy !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_exec got busy %b rdy %b want 1 0",
               arb_busy, req0_ready);
    end
    tick();
    checks++;
    if ({req0_wr, req0_ready} !== 2'b11 || req0_rd !== 32'h12345678) begin
      errors++;
      $display("FAIL single_resp got wr %b rdy %b rd %h want 1 1 12345678",
               req0_wr, req0_ready, req0_rd);
    end
    checks++;
    if ({req1_wr, req1_ready} !== 2'b00 || req1_rd !== 32'h0) begin
      errors++;
      $display("FAIL single_other got %b %b %h want 0 0 0",
               req1_wr, req1_ready, req1_rd);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b0 || req0_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_t3 got busy %b wr %b want 0 0",
               arb_busy, req0_wr);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_rd;
    int exp_g;
    cop_rst    = 1'b1;
    req0_valid = 1'b1;
    req0_insn  = 32'h4000002B;
    req0_rs1   = 32'hA0A0A0A0;
    req0_rs2   = 32'h0;
    req0_rdywr = 1'b1;
    req1_valid = 1'b1;
    req1_insn  = 32'h0000102B;
    req1_rs1   = 32'h0B0B0B0B;
    req1_rs2   = 32'h0;
    req1_rdywr = 1'b1;
    tick();
    cop_rst = 1'b0;
    for (int op = 0; op < 4; op++) begin
      exp_g  = op % 2;
      exp_rd = (exp_g == 0) ? 32'hA0A0A0A0 : 32'h0B0B0B0B;
      #1;
      checks++;
      if (arb_busy !== 1'b0) begin
        errors++;
        $display("FAIL cont_gap op %0d got busy %b want 0", op, arb_busy);
      end
      tick();
      tick();
      checks++;
      if (req0_wr !== (exp_g == 0) || req1_wr !== (exp_g == 1)) begin
        errors++;
        $display("FAIL cont_rr op %0d got wr %b%b want grant %0d",
                 op, req1_wr, req0_wr, exp_g);
      end
      checks++;
      if ((req0_rd | req1_rd) !== exp_rd) begin
        errors++;
        $display("FAIL cont_rd op %0d got %h want %h",
                 op, req0_rd | req1_rd, exp_rd);
      end
      checks++;
      if ({f0_wr, f1_wr} !== 2'b10 || f0_rd !== 32'hA0A0A0A0) begin
        errors++;
        $display("FAIL cont_fp op %0d got wr %b%b rd %h want 10 a0a0a0a0",
                 op, f0_wr, f1_wr, f0_rd);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    req1_valid = 1'b1;
    req1_insn  = 32'h0000102B;
    req1_rs1   = 32'hDEADBEEF;
    req1_rs2   = 32'h0000FFFF;
    req1_rdywr = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 5; i++) begin
      req1_rs1 = i;
      #1;
      checks++;
      if ({req1_wr, req1_ready} !== 2'b10 || req1_rd !== 32'hDEAD4110) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got wr %b rdy %b rd %h want 1 0 dead4110",
                 i, req1_wr, req1_ready, req1_rd);
      end
      checks++;
      if ({req0_wr, req0_ready} !== 2'b00 || req0_rd !== 32'h0) begin
        errors++;
        $display("FAIL bp_other cyc %0d got %b %b %h want 0 0 0",
                 i, req0_wr, req0_ready, req0_rd);
      end
      tick();
    end
    req1_rdywr = 1'b1;
    #1;
    checks++;
    if ({req1_wr, req1_ready} !== 2'b11 || req1_rd !== 32'hDEAD4110) begin
      errors++;
      $display("FAIL bp_release got wr %b rdy %b rd %h want 1 1 dead4110",
               req1_wr, req1_ready, req1_rd);
    end
    tick();
    req1_valid = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_done got busy %b rdy %b want 0 0",
               arb_busy, req1_ready);
    end
  endtask

  task automatic test_unsupported();
    req0_valid = 1'b1;
    req0_insn  = 32'h00000033;
    req0_rs1   = 32'h1;
    req0_rs2   = 32'h2;
    req0_rdywr = 1'b1;
    tick();
    checks++;
    if ({req0_ready, req0_wr, arb_busy} !== 3'b101) begin
      errors++;
      $display("FAIL unsup_exec got rdy %b wr %b busy %b want 1 0 1",
               req0_ready, req0_wr, arb_busy);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req0_wr, arb_busy} !== 3'b000) begin
      errors++;
      $display("FAIL unsup_idle got rdy %b wr %b busy %b want 0 0 0",
               req0_ready, req0_wr, arb_busy);
    end
  endtask

  task automatic test_withdraw();
    req0_valid = 1'b1;
    req0_insn  = 32'h4000002B;
    req0_rs1   = 32'h55;
    req0_rs2   = 32'h0;
    req0_rdywr = 1'b0;
    tick();
    tick();
    checks++;
    if (req0_wr !== 1'b1 || req0_rd !== 32'h55) begin
      errors++;
      $display("FAIL wd_resp got wr %b rd %h want 1 55", req0_wr, req0_rd);
    end
    req0_valid = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL wd_ready got %b want 0", req0_ready);
    end
    tick();
    checks++;
    if ({arb_busy, req0_wr, req0_ready} !== 3'b000) begin
      errors++;
      $display("FAIL wd_idle got busy %b wr %b rdy %b want 0 0 0",
               arb_busy, req0_wr, req0_ready);
    end
  endtask

  task automatic test_reset_exec();
    req1_valid = 1'b1;
    req1_insn  = 32'h0000202B;
    req1_rs1   = 32'h0F0F0000;
    req1_rs2   = 32'h000000F0;
    req1_rdywr = 1'b1;
    tick();
    checks++;
    if (arb_busy !== 1'b1 || dp_insn !== 32'h0000202B) begin
      errors++;
      $display("FAIL rx_exec got busy %b insn %h want 1 0000202b",
               arb_busy, dp_insn);
    end
    cop_rst = 1'b1;
    #1;
    checks++;
    if ({arb_busy, req1_ready, req1_wr} !== 3'b000 ||
        {dp_insn, dp_rs1, req1_rd} !== '0) begin
      errors++;
      $display("FAIL rx_abort got busy %b rdy %b wr %b insn %h want 0",
               arb_busy, req1_ready, req1_wr, dp_insn);
    end
    tick();
    cop_rst = 1'b0;
    tick();
    checks++;
    if (arb_busy !== 1'b1 || dp_rs1 !== 32'h0F0F0000) begin
      errors++;
      $display("FAIL rx_regrant got busy %b rs1 %h want 1 0f0f0000",
               arb_busy, dp_rs1);
    end
    tick();
    checks++;
    if ({req1_wr, req1_ready} !== 2'b11 || req1_rd !== 32'h0F0F00F0) begin
      errors++;
      $display("FAIL rx_resp got wr %b rdy %b rd %h want 1 1 0f0f00f0",
               req1_wr, req1_ready, req1_rd);
    end
    tick();
    req1_valid = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rx_idle got busy %b want 0", arb_busy);
    end
  endtask

  initial begin
    cop_rst    = 1'b1;
    req0_valid = 1'b0;
    req0_insn  = '0;
    req0_rs1   = '0;
    req0_rs2   = '0;
    req0_rdywr = 1'b0;
    req1_valid = 1'b0;
    req1_insn  = '0;
    req1_rs1   = '0;
    req1_rs2   = '0;
    req1_rdywr = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_unsupported();
    test_withdraw();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
